// File: rtl/p2s_tx_pkg.sv
// Shared definitions for the parallel-to-serial transmitter and its s2p peer.
`timescale 1ns/1ps
package p2s_tx_pkg;

  // Word width shared with s2p so both ends of the serial link agree.
  localparam int P2S_DEFAULT_WIDTH = 4;

  // Shifter state: empty, or actively driving bits onto so.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : p2s_tx_pkg

// File: rtl/p2s_hold_buf.sv
// One-word holding buffer between the input handshake and the shifter.
// Owns the full flag and the registered ready that the source sees.
`timescale 1ns/1ps
module p2s_hold_buf
  import p2s_tx_pkg::*;
#(
  parameter int WIDTH = P2S_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,       // accepted word goes into the buffer
  input  logic             drain_i,      // shifter takes the buffered word
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             full_next_o,  // occupancy after the coming edge
  output logic             ready_o
);

  logic             full_q, full_d;
  logic             ready_q;
  logic [WIDTH-1:0] data_q;

  // A load always wins; otherwise a drain empties the entry.
  always_comb begin
    full_d = load_i | (full_q & ~drain_i);
  end

  // Full flag and ready; ready stays low during reset and rises one edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks, so every register
      // samples pre-edge values regardless of statement order.
      full_q  <= full_d;
      ready_q <= ~full_d;
    end
  end

  // Buffered word payload, written only on load.
  // NOTE: data registers carry no reset; the full flag alone says whether
  // the contents are meaningful, so resetting them would be dead logic.
  always_ff @(posedge clk) begin
    if (load_i) data_q <= data_i;
  end

  assign data_o      = data_q;
  assign full_o      = full_q;
  assign full_next_o = full_d;
  assign ready_o     = ready_q;

endmodule : p2s_hold_buf

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: valid/ready word input, one bit per clock
// on so with dat_en marking each valid bit. A holding buffer lets words
// stream back to back with no gap in dat_en.
`timescale 1ns/1ps
module p2s_tx
  import p2s_tx_pkg::*;
#(
  parameter  int WIDTH     = P2S_DEFAULT_WIDTH,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             dat_en,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] shifted;
  logic             so_q, so_d;
  logic             dat_en_q;
  logic             busy_q;

  logic             accept;
  logic             last_bit;
  logic             buf_load, buf_drain;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full, buf_full_next, buf_ready;

  // Bit currently presented on the line for a given shifter content.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  p2s_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (buf_load),
    .drain_i     (buf_drain),
    .data_i      (din),
    .data_o      (buf_data),
    .full_o      (buf_full),
    .full_next_o (buf_full_next),
    .ready_o     (buf_ready)
  );

  assign accept   = din_valid & buf_ready;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign shifted  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  // Next-state for FSM, bit counter, shifter and buffer strobes.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sh_d    = din;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          if (buf_full) begin
            sh_d      = buf_data;
            buf_drain = 1'b1;
          end else if (accept) begin
            sh_d = din;                 // bypass straight into the shifter
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          sh_d  = shifted;
          if (accept) buf_load = 1'b1;
        end
      end
    endcase
    so_d = (state_d == ST_SHIFT) ? head_bit(sh_d) : 1'b0;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      so_q     <= 1'b0;
      dat_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      so_q     <= so_d;
      dat_en_q <= (state_d == ST_SHIFT);
      busy_q   <= (state_d == ST_SHIFT) | buf_full_next;
    end
  end

  // Shift register payload; only meaningful while in ST_SHIFT.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign din_ready = buf_ready;
  assign so        = so_q;
  assign dat_en    = dat_en_q;
  assign busy      = busy_q;

endmodule : p2s_tx

// File: tb/tb_p2s_tx.sv
// Self-checking bench for p2s_tx: a bit-queue model predicts so/dat_en/
// din_ready/busy every cycle, and literal expectations pin the model.
`timescale 1ns/1ps
module tb_p2s_tx;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready, so, dat_en, busy;

  logic [W-1:0] din2;
  logic         din_valid2;
  logic         din_ready2, so2, dat_en2, busy2;

  int total = 0;
  int bad   = 0;

  // Model: bits still owed on the line, front = bit on so right now.
  bit           mq[$];
  bit           m_ready;

  // Observation logs of the MSB-first DUT.
  int           cyc = 0;
  bit           so_log[$];
  int           en_cyc[$];
  logic [W-1:0] rx_sh = '0;
  int           rx_n = 0;
  logic [W-1:0] rx_q[$];

  p2s_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .so        (so),
    .dat_en    (dat_en),
    .busy      (busy)
  );

  p2s_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din2),
    .din_valid (din_valid2),
    .din_ready (din_ready2),
    .so        (so2),
    .dat_en    (dat_en2),
    .busy      (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one bit leaves per clock, an accepted word appends its bits;
  // ready means at most one word is owed after the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ready <= 1'b0;
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      if (din_valid && m_ready)
        for (int i = W - 1; i >= 0; i--) mq.push_back(din[i]);
      m_ready <= (mq.size() <= W);
    end
  end

  always @(negedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the model, plus logging and an s2p-style
  // MSB-first word assembler on the serial output.
  always @(negedge clk) begin
    if (rst_n) begin
      check("so",        so,        (mq.size() != 0) ? mq[0] : 1'b0);
      check("dat_en",    dat_en,    mq.size() != 0);
      check("din_ready", din_ready, m_ready);
      check("busy",      busy,      mq.size() != 0);
      if (dat_en) begin
        so_log.push_back(so);
        en_cyc.push_back(cyc);
        rx_sh <= {rx_sh[W-2:0], so};
        if (rx_n == W - 1) begin
          rx_q.push_back({rx_sh[W-2:0], so});
          rx_n <= 0;
        end else begin
          rx_n <= rx_n + 1;
        end
      end
    end else begin
      rx_n <= 0;
    end
  end

  // Present one word (called just after a negedge); returns after the
  // accept edge, at the following negedge, with the number of stalled edges.
  task automatic send(input logic [W-1:0] w, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (m_ready) done = 1'b1;
      else         stalls++;
      @(posedge clk);
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("send_accepted", done, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && mq.size() != 0; i++) @(negedge clk);
    check("drain_bounded", mq.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st, s, rs, ec;
    logic [W-1:0] stream_words [4];
    stream_words[0] = 4'b1010;
    stream_words[1] = 4'b0101;
    stream_words[2] = 4'b0011;
    stream_words[3] = 4'b1100;

    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    din2       = '0;
    din_valid2 = 1'b0;

    // Reset state.
    #100;
    check("rst_so",     so,        1'b0);
    check("rst_dat_en", dat_en,    1'b0);
    check("rst_ready",  din_ready, 1'b0);
    check("rst_busy",   busy,      1'b0);
    check("rst_ready2", din_ready2, 1'b0);
    #100.1 rst_n = 1'b1;
    #2;
    check("ready_before_edge", din_ready, 1'b0);
    @(negedge clk);
    check("ready_after_release", din_ready, 1'b1);

    // Single word 1010.
    s = so_log.size();
    rs = rx_q.size();
    send(4'b1010, st);
    check("single_stalls", st, 0);
    wait_drain();
    check("single_busy_low", busy, 1'b0);
    check("single_en_cycles", so_log.size() - s, 4);
    check("single_bit0", so_log[s],     1'b1);
    check("single_bit1", so_log[s + 1], 1'b0);
    check("single_bit2", so_log[s + 2], 1'b1);
    check("single_bit3", so_log[s + 3], 1'b0);
    check("single_word", rx_q[rs], 4'b1010);
    repeat (2) @(negedge clk);

    // Streaming 1010 0101 0011 1100 with valid held.
    s  = so_log.size();
    rs = rx_q.size();
    ec = en_cyc.size();
    for (int i = 0; i < 4; i++) begin
      send(stream_words[i], st);
      check("stream_stalls", st, (i < 2) ? 0 : 3);
    end
    wait_drain();
    check("stream_en_cycles", so_log.size() - s, 16);
    check("stream_contiguous", en_cyc[ec + 15] - en_cyc[ec], 15);
    check("stream_word_count", rx_q.size() - rs, 4);
    for (int i = 0; i < 4; i++) check("stream_word", rx_q[rs + i], stream_words[i]);
    repeat (2) @(negedge clk);

    // Backpressure: 1111 held while the buffer is full.
    rs = rx_q.size();
    send(4'b1010, st);
    send(4'b0101, st);
    send(4'b1111, st);
    check("bp_stalls", st, 3);
    wait_drain();
    repeat (3) @(negedge clk);
    check("bp_word_count", rx_q.size() - rs, 3);
    check("bp_word0", rx_q[rs],     4'b1010);
    check("bp_word1", rx_q[rs + 1], 4'b0101);
    check("bp_word2", rx_q[rs + 2], 4'b1111);

    // Reset after two bits of 1100 with 0011 buffered.
    send(4'b1100, st);
    send(4'b0011, st);
    check("mid_second_bit", so, 1'b1);
    check("mid_buf_full", din_ready, 1'b0);
    #5 rst_n = 1'b0;
    #1;
    check("async_so",     so,        1'b0);
    check("async_dat_en", dat_en,    1'b0);
    check("async_ready",  din_ready, 1'b0);
    check("async_busy",   busy,      1'b0);
    @(negedge clk);
    @(negedge clk);
    #0.1 rst_n = 1'b1;
    #2;
    check("rel_ready_before_edge", din_ready, 1'b0);
    @(negedge clk);
    check("rel_ready_after_edge", din_ready, 1'b1);
    check("rel_idle_en", dat_en, 1'b0);
    s  = so_log.size();
    rs = rx_q.size();
    send(4'b0110, st);
    wait_drain();
    repeat (3) @(negedge clk);
    check("rel_word_count", rx_q.size() - rs, 1);
    check("rel_word", rx_q[rs], 4'b0110);
    check("rel_bit0", so_log[s],     1'b0);
    check("rel_bit1", so_log[s + 1], 1'b1);
    check("rel_bit2", so_log[s + 2], 1'b1);
    check("rel_bit3", so_log[s + 3], 1'b0);

    // LSB-first instance: 0001 goes out as 1,0,0,0.
    check("lsb_ready", din_ready2, 1'b1);
    din2       = 4'b0001;
    din_valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("lsb_so", so2, (i == 0) ? 1'b1 : 1'b0);
      check("lsb_en", dat_en2, 1'b1);
      @(negedge clk);
    end
    check("lsb_end_en",   dat_en2, 1'b0);
    check("lsb_end_so",   so2,     1'b0);
    check("lsb_end_busy", busy2,   1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_p2s_tx

// File: doc/p2s_tx.md
Name: p2s_tx

Overview:
Parallel-to-serial transmitter that sits directly upstream of s2p and drives its si/dat_en inputs. It accepts WIDTH-bit words over a valid/ready handshake. Each word is shifted out one bit per clock, with dat_en high for each valid bit. A one-word holding buffer allows back-to-back words to stream with no gap in dat_en.

Parameters:
WIDTH, 4, word width in bits (>=2)
MSB_FIRST, 1, 1 = din[WIDTH-1] sent first; 0 = din[0] sent first
CNT_W, $clog2(WIDTH), bit counter width (derived, not overridden)

Ports:
clk  input  1  system clock (50 MHz nominal)
rst_n  input  1  reset, asynchronous assert, active-low
din  input  WIDTH  parallel word to send
din_valid  input  1  din holds a word
din_ready  output  1  block can accept a word this cycle
so  output  1  serial data, to s2p si
dat_en  output  1  so carries a valid bit, to s2p dat_en
busy  output  1  shifter active or holding buffer full

Behaviour:
- Single clock domain; all outputs registered. Async reset: so=0, dat_en=0, din_ready=0, busy=0, buffer empty, state=IDLE, bit_cnt=0.
- din_ready rises on the first clk edge after rst_n deasserts. After that, din_ready = !buf_full as seen after the current edge (registered next-state).
- Accept: din_valid && din_ready at a rising edge. din is sampled at that edge.
- State IDLE (shifter empty): an accepted word loads straight into the shift register. State -> SHIFT, bit_cnt=0. First bit on so and dat_en=1 starting the same edge. Latency is 1 clock from accept edge to first bit.
- State SHIFT: one bit per clock, bit_cnt increments.
  - An accept during SHIFT writes the holding buffer; buf_full=1 and din_ready=0 next cycle.
- Last-bit edge (bit_cnt==WIDTH-1):
  - Buffer full: the buffer moves to the shifter, buffer clears, bit_cnt=0, stays SHIFT, no dat_en gap.
  - Buffer empty and accept at the same edge: the word bypasses into the shifter, no gap.
  - Buffer empty and no accept: -> IDLE, dat_en=0, so=0.
- Buffer full and din_valid held: no accept and no overwrite. The word is taken only after din_ready returns; no drop, no duplicate.
- In IDLE, so is forced 0 regardless of prior data.
- busy = (state==SHIFT) || buf_full.
- din changing while din_ready=0 has no effect.
- rst_n low mid-word: outputs go to reset values immediately. The partial word and buffer are discarded; no resume after release.
- Bit order: MSB_FIRST=1 shifts left and outputs the top bit; MSB_FIRST=0 shifts right and outputs bit 0. This must match s2p's fill order; MSB_FIRST=1 is the system setting.
- Sustained throughput: one word per WIDTH clocks, 100% dat_en duty while the source keeps up.

Decomposition:
- Shared constants/header: state encodings (ST_IDLE, ST_SHIFT); default WIDTH shared with s2p so both ends agree.
- One natural sub-module: p2s_hold_buf, the one-entry register with full flag, load/drain strobes and the ready computation. The top level holds the FSM, counter and shifter.

Test Plan:
Setup for all scenarios: WIDTH=4, 20 ns clock, rst_n released at 200.1 ns.
- Single word: din=4'b1010, one-cycle din_valid -> so=1,0,1,0 on 4 consecutive clocks; dat_en high exactly 4 cycles; busy drops to 0 on the following cycle.
- Streaming: din 1010,0101,0011,1100 presented with din_valid held -> 16 contiguous dat_en cycles, so=1010 0101 0011 1100. din_ready deasserts after the 2nd accept and toggles once per word thereafter.
- Backpressure: buffer full, din_valid held with din=4'b1111 for 3 extra cycles -> exactly one 1111 word emitted, no duplicate, nothing lost.
- Reset mid-operation: rst_n low after 2 bits of 1100 with 0011 buffered -> so=0, dat_en=0, din_ready=0 asynchronously. After release, din_ready=1 one edge later; the next word 0110 sends cleanly.
- Loopback into s2p #(4): stream from the Streaming scenario -> s2p pulses dat_valid 4 times with po=1010, 0101, 0011, 1100 in order.
- MSB_FIRST=0: din=4'b0001 -> so=1,0,0,0.
